// File: rtl/seg_pkg.sv
// Shared constants, segment codes and helpers for the six-digit dynamic display.
// Codes are active-low: bit 7 = dp, bits 6..0 = g..a.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DATA_W     = 20;
    localparam int BCD_W      = 24;

    localparam logic [DATA_W-1:0] DATA_MAX = 20'd999_999;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_dynamic_if.sv
// Display-side bundle: value/control inputs toward the scanner, sel/seg back out.
interface seg_dynamic_if;
    import seg_pkg::*;

    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] point;
    logic                  sign;
    logic                  seg_en;
    logic [NUM_DIGITS-1:0] sel;
    logic [7:0]            seg;

    modport master (output data, point, sign, seg_en, input sel, seg);
    modport slave  (input data, point, sign, seg_en, output sel, seg);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 20 shifts per value.
// done is high for the single DONE cycle while bcd holds the finished result.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam logic [4:0] LAST_ITER = 5'(DATA_W - 1);

    conv_state_t       state, next_state;
    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_work;
    logic [4:0]        iter;

    always_ff @(posedge clk) begin
        if (rst) state <= CONV_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CONV_IDLE:  if (start) next_state = CONV_SHIFT;
            CONV_SHIFT: if (iter == LAST_ITER) next_state = CONV_DONE;
            CONV_DONE:  next_state = CONV_IDLE;
            default:    next_state = CONV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != CONV_IDLE);
        done = (state == CONV_DONE);
    end

    // Binary bits shift out of bin_q into the BCD accumulator, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_work <= '0;
            iter     <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        bin_q    <= bin;
                        bcd_work <= '0;
                        iter     <= '0;
                    end
                end
                CONV_SHIFT: begin
                    {bcd_work, bin_q} <= {dabble_adjust(bcd_work), bin_q} << 1;
                    iter              <= iter + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = bcd_work;

endmodule

// File: rtl/seg_dynamic.sv
// Six-digit scan driver: clamps and converts the value to BCD, then multiplexes
// one digit per SCAN_CYCLES with leading-zero blanking, sign and decimal points.
module seg_dynamic
    import seg_pkg::*;
#(
    parameter int SCAN_CYCLES = 50_000
)(
    input  logic         clk,
    input  logic         rst,
    seg_dynamic_if.slave bus
);

    localparam int CNT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DATA_W-1:0]     data_clamped, last_q;
    logic                  valid_q, conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]      conv_bcd, bcd_q;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            idx, high_digit, high_point, show_top;
    logic [3:0]            cur_digit;
    logic [7:0]            seg_next, seg_q;
    logic [NUM_DIGITS-1:0] sel_next, sel_q;

    assign data_clamped = (bus.data > DATA_MAX) ? DATA_MAX : bus.data;
    assign conv_start   = !conv_busy && (!valid_q || data_clamped != last_q);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (data_clamped),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // bcd_q only ever loads a finished conversion, so no partial value is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= '0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
        end else begin
            if (conv_start) last_q <= data_clamped;
            if (conv_done) begin
                bcd_q   <= conv_bcd;
                valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digits above the higher of the top nonzero digit and the top dp are blank.
    always_comb begin
        high_digit = '0;
        high_point = '0;
        cur_digit  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) high_digit = 3'(i);
            if (bus.point[i])            high_point = 3'(i);
            if (idx == 3'(i))            cur_digit  = bcd_q[4*i +: 4];
        end
        show_top = (high_point > high_digit) ? high_point : high_digit;
        if (idx <= show_top)
            seg_next = digit_code(cur_digit);
        else if (bus.sign && show_top < 3'd5 && idx == show_top + 3'd1)
            seg_next = SEG_MINUS;
        else
            seg_next = SEG_BLANK;
        if (bus.point[idx]) seg_next[7] = 1'b0;
        sel_next = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.seg_en) begin
            sel_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            sel_q <= sel_next;
            seg_q <= seg_next;
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;

endmodule
